// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interrupt sequencer (clint).
// Holds CSR addresses, instruction encodings, cause codes, pipeline
// control constants, the sequencer state encoding and mstatus helpers.
package clint_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    // System instruction encodings recognised in ID
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // mcause values
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL     = 32'd11;
    localparam logic [31:0] CAUSE_TIMER_INT = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT_INT   = 32'h8000_000B;

    // Pipeline control levels shared with the controller
    localparam logic HOLD_ENABLE  = 1'b1;
    localparam logic HOLD_DISABLE = 1'b0;
    localparam logic JUMP_ENABLE  = 1'b1;
    localparam logic JUMP_DISABLE = 1'b0;

    typedef logic [31:0] inst_addr_t;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Sequencer states: trap path is MEPC..ASSERT, mret path is MRET_*
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MCAUSE  = 3'd2,
        S_MSTATUS = 3'd3,
        S_ASSERT  = 3'd4,
        S_MRET_ST = 3'd5,
        S_MRET_AS = 3'd6
    } state_e;

    // Trap entry: MPIE takes the old MIE, MIE is cleared
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: MIE takes the old MPIE, MPIE is set
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer.
// Detects ecall/ebreak/mret in ID and enabled level interrupts, holds the
// pipeline, writes mepc/mcause/mstatus through the CSR port and then issues
// a one-cycle fetch redirect.
// Optional build macro CLINT_VECTORED_EN: async traps honour vectored mtvec
// mode (mtvec[1:0]==2'b01); otherwise the redirect is always the mtvec base.
module clint
    import clint_pkg::*;
#(
    parameter int INT_NUM   = 8,
    parameter int TIMER_BIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [31:0]        inst_i,
    input  inst_addr_t         inst_addr_i,
    input  logic               jump_flag_i,
    input  inst_addr_t         jump_addr_i,
    input  logic               div_started_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [11:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output inst_addr_t         int_addr_o
);

    state_e      state_q;
    logic [31:0] cause_q;
    logic        async_q;
    logic        we_q;
    logic [11:0] waddr_q;
    logic [31:0] data_q;
    logic        int_assert_q;
    inst_addr_t  int_addr_q;

    logic        async_req;
    logic        sync_req;
    logic        mret_req;
    logic [31:0] cause_d;
    inst_addr_t  epc_d;
    inst_addr_t  trap_base;
    inst_addr_t  trap_target;

    // Request detection and cause/epc selection for the current ID cycle
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        async_req = (|int_flag_i) && csr_mstatus_i[MSTATUS_MIE];
        sync_req  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
        mret_req  = (inst_i == INST_MRET);
        cause_d   = CAUSE_ECALL;
        epc_d     = inst_addr_i;
        if (async_req) begin
            cause_d = int_flag_i[TIMER_BIT] ? CAUSE_TIMER_INT : CAUSE_EXT_INT;
            if (jump_flag_i) begin
                epc_d = jump_addr_i;
            end else if (div_started_i) begin
                // The divider owns the instruction ahead; resume there (wraps mod 2^32).
                epc_d = inst_addr_i - 32'd4;
            end
        end else if (inst_i == INST_EBREAK) begin
            cause_d = CAUSE_EBREAK;
        end
    end

    // Trap vector target, optionally vectored for asynchronous causes
    always_comb begin
        trap_base = {csr_mtvec_i[31:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (async_q && (csr_mtvec_i[1:0] == 2'b01)) begin
            trap_target = trap_base + {cause_q[29:0], 2'b00};
        end else begin
            trap_target = trap_base;
        end
`else
        trap_target = trap_base;
`endif
    end

`ifndef CLINT_VECTORED_EN
    // Mode bits and the async marker only matter for vectored redirects.
    logic unused_vec_mode;
    assign unused_vec_mode = ^{csr_mtvec_i[1:0], async_q};
`endif

    // Sequencer FSM with registered CSR-write and redirect outputs
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cause_q      <= '0;
            async_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            int_assert_q <= JUMP_DISABLE;
            int_addr_q   <= '0;
        end else begin
            we_q         <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            int_assert_q <= JUMP_DISABLE;
            int_addr_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (async_req || sync_req) begin
                        state_q <= S_MEPC;
                        cause_q <= cause_d;
                        async_q <= async_req;
                        we_q    <= 1'b1;
                        waddr_q <= CSR_MEPC;
                        data_q  <= epc_d;
                    end else if (mret_req) begin
                        state_q <= S_MRET_ST;
                        we_q    <= 1'b1;
                        waddr_q <= CSR_MSTATUS;
                        data_q  <= mret_mstatus(csr_mstatus_i);
                    end
                end
                S_MEPC: begin
                    state_q <= S_MCAUSE;
                    we_q    <= 1'b1;
                    waddr_q <= CSR_MCAUSE;
                    data_q  <= cause_q;
                end
                S_MCAUSE: begin
                    state_q <= S_MSTATUS;
                    we_q    <= 1'b1;
                    waddr_q <= CSR_MSTATUS;
                    data_q  <= trap_mstatus(csr_mstatus_i);
                end
                S_MSTATUS: begin
                    state_q      <= S_ASSERT;
                    int_assert_q <= JUMP_ENABLE;
                    int_addr_q   <= trap_target;
                end
                S_MRET_ST: begin
                    state_q      <= S_MRET_AS;
                    int_assert_q <= JUMP_ENABLE;
                    int_addr_q   <= csr_mepc_i;
                end
                default: begin
                    // S_ASSERT and S_MRET_AS: redirect issued, return to detection.
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Hold in the detection cycle and throughout any sequence; forced low in reset.
    always_comb begin
        hold_flag_o = HOLD_DISABLE;
        if (state_q != S_IDLE) begin
            hold_flag_o = HOLD_ENABLE;
        end else if (rst && (async_req || sync_req || mret_req)) begin
            hold_flag_o = HOLD_ENABLE;
        end
    end

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign data_o       = data_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model that
// also acts as the CSR file (applies the expected CSR writes).
module tb_clint;

    localparam int INT_NUM   = 8;
    localparam int TIMER_BIT = 0;

    logic               clk = 1'b0;
    logic               rst;
    logic [INT_NUM-1:0] int_flag_i;
    logic [31:0]        inst_i;
    logic [31:0]        inst_addr_i;
    logic               jump_flag_i;
    logic [31:0]        jump_addr_i;
    logic               div_started_i;
    logic [31:0]        csr_mtvec_i;
    logic [31:0]        csr_mepc_i;
    logic [31:0]        csr_mstatus_i;
    logic               hold_flag_o;
    logic               we_o;
    logic [11:0]        waddr_o;
    logic [31:0]        data_o;
    logic               int_assert_o;
    logic [31:0]        int_addr_o;

    int tests_run    = 0;
    int tests_failed = 0;

    clint #(.INT_NUM(INT_NUM), .TIMER_BIT(TIMER_BIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .int_flag_i    (int_flag_i),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .div_started_i (div_started_i),
        .csr_mtvec_i   (csr_mtvec_i),
        .csr_mepc_i    (csr_mepc_i),
        .csr_mstatus_i (csr_mstatus_i),
        .hold_flag_o   (hold_flag_o),
        .we_o          (we_o),
        .waddr_o       (waddr_o),
        .data_o        (data_o),
        .int_assert_o  (int_assert_o),
        .int_addr_o    (int_addr_o)
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle
    typedef struct {
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] data;
        logic        ia;
        logic [31:0] iaddr;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t rec(logic h, logic w, logic [11:0] a, logic [31:0] d,
                                 logic i, logic [31:0] t);
        exp_t e;
        e.hold = h; e.we = w; e.waddr = a; e.data = d; e.ia = i; e.iaddr = t;
        return e;
    endfunction

    // Where a trap lands, from the mtvec rules
    function automatic logic [31:0] trap_pc(logic is_async, logic [31:0] cause);
        logic [31:0] base;
        base = csr_mtvec_i & 32'hFFFF_FFFC;
`ifdef CLINT_VECTORED_EN
        if (is_async && (csr_mtvec_i % 4 == 1)) base = base + 4 * (cause & 32'h7FFF_FFFF);
`endif
        return base;
    endfunction

    // Model: either continue a planned sequence or decide from this cycle's inputs
    function automatic exp_t model_now();
        logic        is_async;
        logic [31:0] cause, epc, ms, new_ms;
        ms = csr_mstatus_i;
        if (exp_q.size() > 0) return exp_q.pop_front();
        is_async = (int_flag_i != 0) && ms[3];
        if (is_async || inst_i == 32'h0000_0073 || inst_i == 32'h0010_0073) begin
            if (is_async) begin
                cause = ((int_flag_i >> TIMER_BIT) & 1) != 0 ? 32'h8000_0007 : 32'h8000_000B;
                epc   = jump_flag_i ? jump_addr_i : (div_started_i ? inst_addr_i - 4 : inst_addr_i);
            end else begin
                cause = (inst_i == 32'h0000_0073) ? 32'd11 : 32'd3;
                epc   = inst_addr_i;
            end
            new_ms = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
            exp_q.push_back(rec(1, 1, 12'h341, epc, 0, 0));
            exp_q.push_back(rec(1, 1, 12'h342, cause, 0, 0));
            exp_q.push_back(rec(1, 1, 12'h300, new_ms, 0, 0));
            exp_q.push_back(rec(1, 0, 0, 0, 1, trap_pc(is_async, cause)));
            return rec(1, 0, 0, 0, 0, 0);
        end
        if (inst_i == 32'h3020_0073) begin
            new_ms = (ms & ~32'h8) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
            exp_q.push_back(rec(1, 1, 12'h300, new_ms, 0, 0));
            exp_q.push_back(rec(1, 0, 0, 0, 1, csr_mepc_i));
            return rec(1, 0, 0, 0, 0, 0);
        end
        return rec(0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check_outputs(input exp_t e);
        check("hold",  {31'd0, hold_flag_o},  {31'd0, e.hold});
        check("we",    {31'd0, we_o},         {31'd0, e.we});
        check("waddr", {20'd0, waddr_o},      {20'd0, e.waddr});
        check("data",  data_o,                e.data);
        check("assert",{31'd0, int_assert_o}, {31'd0, e.ia});
        check("iaddr", int_addr_o,            e.iaddr);
    endtask

    // One clock: compare mid-cycle, then commit expected CSR writes after the edge
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        e = model_now();
        check_outputs(e);
        @(posedge clk);
        #1;
        if (e.we && e.waddr == 12'h341) csr_mepc_i    = e.data;
        if (e.we && e.waddr == 12'h300) csr_mstatus_i = e.data;
    endtask

    task automatic quiet();
        int_flag_i = '0; inst_i = 32'h0000_0013; jump_flag_i = 0; div_started_i = 0;
    endtask

    initial begin
        rst = 1'b0;
        quiet();
        inst_addr_i = 0; jump_addr_i = 0;
        csr_mtvec_i = 32'h200; csr_mepc_i = 0; csr_mstatus_i = 32'h8;
        @(posedge clk); @(posedge clk); #1;
        check_outputs(rec(0, 0, 0, 0, 0, 0));
        rst = 1'b1;

        // ecall: three CSR writes then redirect to mtvec base
        inst_i = 32'h0000_0073; inst_addr_i = 32'h100;
        cycle();
        quiet();
        repeat (4) cycle();
        check("ecall_mstatus", csr_mstatus_i, 32'h80);

        // timer interrupt during an EX redirect
        csr_mstatus_i = 32'h8; int_flag_i = 8'h01; jump_flag_i = 1; jump_addr_i = 32'h340;
        cycle();
        quiet();
        repeat (4) cycle();
        check("timer_mepc", csr_mepc_i, 32'h340);

        // external interrupt masked, then enabled behind a busy divider
        int_flag_i = 8'h04; csr_mstatus_i = 32'h0;
        cycle();
        csr_mstatus_i = 32'h8; div_started_i = 1; inst_addr_i = 32'h50;
        cycle();
        quiet();
        repeat (4) cycle();
        check("ext_mepc", csr_mepc_i, 32'h4C);

        // mret
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; inst_i = 32'h3020_0073;
        cycle();
        quiet();
        repeat (2) cycle();
        check("mret_mstatus", csr_mstatus_i, 32'h88);

        // reset in MCAUSE abandons the sequence
        inst_i = 32'h0000_0073; inst_addr_i = 32'h100;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check_outputs(rec(0, 0, 0, 0, 0, 0));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) cycle();

        // vectored-mode mtvec with a timer interrupt, then an ecall
        quiet(); csr_mtvec_i = 32'h201; csr_mstatus_i = 32'h8; int_flag_i = 8'h01;
        cycle();
        quiet();
        repeat (4) cycle();
        inst_i = 32'h0000_0073;
        cycle();
        quiet();
        repeat (4) cycle();

        // randomized traffic
        csr_mstatus_i = $urandom;
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0) begin
                if ($urandom_range(0, 7) == 0) csr_mstatus_i = csr_mstatus_i | 32'h8;
                if ($urandom_range(0, 15) == 0) csr_mtvec_i = ($urandom & 32'hFFFF_FFFC) | $urandom_range(0, 1);
            end
            case ($urandom_range(0, 7))
                0: inst_i = 32'h0000_0073;
                1: inst_i = 32'h0010_0073;
                2: inst_i = 32'h3020_0073;
                default: inst_i = $urandom;
            endcase
            int_flag_i    = ($urandom_range(0, 3) == 0) ? INT_NUM'($urandom) : '0;
            jump_flag_i   = $urandom_range(0, 1) == 1;
            div_started_i = $urandom_range(0, 1) == 1;
            inst_addr_i   = $urandom;
            jump_addr_i   = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interrupt/exception sequencer; sits directly upstream of the pipeline controller and drives its hold_flag_clint_i input.
- Detects ecall/ebreak/mret in the ID stage and pending external/timer interrupts.
- Stalls the pipeline via hold_flag_o, writes mepc/mcause/mstatus through the CSR write port, then redirects fetch with a one-cycle int_assert_o/int_addr_o.

Parameters:
- INT_NUM, 8, width of int_flag_i.
- TIMER_BIT, 0, index of int_flag_i carrying the machine-timer interrupt.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- int_flag_i  input  INT_NUM  level interrupt requests.
- inst_i  input  32  instruction in ID.
- inst_addr_i  input  32  PC of inst_i.
- jump_flag_i  input  1  EX redirect this cycle.
- jump_addr_i  input  32  EX redirect target.
- div_started_i  input  1  divider busy with the instruction ahead.
- csr_mtvec_i  input  32  current mtvec.
- csr_mepc_i  input  32  current mepc.
- csr_mstatus_i  input  32  current mstatus.
- hold_flag_o  output  1  pipeline hold request to the controller.
- we_o  output  1  CSR write enable.
- waddr_o  output  12  CSR write address.
- data_o  output  32  CSR write data.
- int_assert_o  output  1  one-cycle fetch redirect.
- int_addr_o  output  32  redirect target.

Behaviour:
- Reset (async, rst=0):
  - FSM to IDLE; all outputs 0.
  - Latched cause/epc cleared.
  - Any sequence in progress is abandoned with no partial CSR write completing.
- Detection, IDLE only, evaluated combinationally on the current cycle. Priority is async > sync > mret:
  - Async condition: int_flag_i != 0 and csr_mstatus_i[3] (MIE) = 1.
    - Cause 0x80000007 if int_flag_i[TIMER_BIT], else 0x8000000B.
    - epc = jump_addr_i if jump_flag_i; else inst_addr_i-4 if div_started_i; else inst_addr_i.
  - Sync condition: inst_i == 0x00000073 (ecall, cause 11) or 0x00100073 (ebreak, cause 3).
    - epc = inst_addr_i.
  - mret condition: inst_i == 0x30200073.
- hold_flag_o = 1 in the detection cycle (combinational) and in every non-IDLE state.
- Trap FSM. Total trap hold = 5 cycles, redirect in the 5th.
  - IDLE → MEPC on detection; cause and epc are latched.
  - MEPC: we_o=1, waddr_o=0x341, data_o=epc.
  - MCAUSE: we_o=1, waddr_o=0x342, data_o=cause.
  - MSTATUS: we_o=1, waddr_o=0x300, data_o=mstatus with bit7 (MPIE) = old bit3 and bit3 (MIE) = 0; other bits unchanged.
  - ASSERT: int_assert_o=1, int_addr_o={csr_mtvec_i[31:2],2'b00}, then back to IDLE.
- mret FSM. Total mret hold = 3 cycles.
  - IDLE → MRET_ST.
  - MRET_ST: we_o=1, waddr_o=0x300, data_o=mstatus with bit3 = old bit7 and bit7 = 1.
  - MRET_AS: int_assert_o=1, int_addr_o=csr_mepc_i, then back to IDLE.
- Outside the write states, we_o=0, waddr_o=0 and data_o=0. int_addr_o=0 whenever int_assert_o=0.
- Inputs are ignored while not in IDLE. A new detection is possible in the cycle after ASSERT/MRET_AS.
- A level interrupt still asserted after the trap does not retrigger, because MIE is now 0.
- Width rules:
  - inst_addr_i-4 wraps modulo 2^32.
  - int_flag_i wider than one bit set: timer wins if its bit is set.

Optional Feature:
- Macro: CLINT_VECTORED_EN.
- Defined: when csr_mtvec_i[1:0]==2'b01 and the trap is async, int_addr_o = {mtvec[31:2],2'b00} + 4*cause[30:0]. Sync traps always use the base.
- Undefined: mode bits are ignored; int_addr_o is always the base.

Decomposition:
- Shared defines file holds:
  - CSR addresses (MEPC, MCAUSE, MSTATUS, MTVEC).
  - Instruction encodings (ECALL, EBREAK, MRET).
  - Cause codes.
  - HoldEnable/JumpEnable and InstAddrBus.
  - FSM state encodings.
- No sub-module; one FSM with a small combinational cause/epc selector.

Test Plan:
- ecall at inst_addr_i=0x100, mstatus=0x8, mtvec=0x200:
  - writes 0x341←0x100, then 0x342←11, then 0x300←0x80;
  - int_assert_o with int_addr_o=0x200 in cycle 5;
  - hold_flag_o high in cycles 1-5.
- int_flag_i=0x01, MIE=1, jump_flag_i=1, jump_addr_i=0x340 → mepc write 0x340, mcause 0x80000007.
- int_flag_i=0x04, MIE=0 → no hold and no writes. Set MIE=1 with div_started_i=1 and inst_addr_i=0x50 → mepc 0x4C, mcause 0x8000000B.
- mret with mstatus=0x80, mepc=0x104 → 0x300←0x88, then int_assert_o with int_addr_o=0x104; hold lasts 3 cycles.
- Drop rst to 0 in the MCAUSE state → all outputs 0 immediately. After release, an ecall restarts from the MEPC write.
- CLINT_VECTORED_EN build, mtvec=0x201, timer interrupt → int_addr_o=0x21C. ecall with the same mtvec → 0x200.
